// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]      r_cnt;
   logic               r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_bzero;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_raw_a;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_load;
   logic               w_last;
   logic               w_sgn;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_q;
   logic [WIDTH-1:0]   w_r;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

   // flush in IDLE suppresses a same-cycle start
   assign w_load  = (r_state == S_IDLE) && start && !flush;
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   // op[0] = 0 selects the signed variants
   assign w_sgn   = ~op[0];
   assign w_a_neg = w_sgn & a[WIDTH-1];
   assign w_b_neg = w_sgn & b[WIDTH-1];
   assign w_abs_a = w_a_neg ? (~a + 1'b1) : a;
   assign w_abs_b = w_b_neg ? (~b + 1'b1) : b;

   // multiply: acc = {partial, multiplier}, shift right each step
   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_acc[0] ? r_opb : '0)};
   assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

   // divide: acc = {remainder, dividend}, shift left each step
   assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
   assign w_div_nxt = w_trial[WIDTH]
                    ? {r_acc[2*WIDTH-2:0], 1'b0}
                    : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   // sign correction applied in FIX
   assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_q    = r_acc[WIDTH-1:0];
   assign w_r    = r_acc[2*WIDTH-1:WIDTH];

   // result mux; divide-by-zero returns all ones and the raw dividend
   always_comb begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
      if (r_div) begin
         if (r_bzero) begin
            w_res_hi = r_raw_a;
            w_res_lo = '1;
         end else begin
            w_res_hi = r_neg_r ? (~w_r + 1'b1) : w_r;
            w_res_lo = r_neg_q ? (~w_q + 1'b1) : w_q;
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_load) w_next = S_RUN;
         S_RUN: begin
            if (flush)       w_next = S_IDLE;
            else if (w_last) w_next = S_FIX;
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // operand latch and per-cycle iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
         r_opb   <= '0;
         r_raw_a <= '0;
         r_acc   <= '0;
      end else if (w_load) begin
         r_cnt   <= '0;
         r_div   <= op[1];
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_bzero <= op[1] & (b == '0);
         r_opb   <= op[1] ? w_abs_b : w_abs_a;
         r_raw_a <= a;
         r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
      end else if (r_state == S_RUN && !flush) begin
         r_cnt   <= r_cnt + 1'b1;
         r_acc   <= r_div ? w_div_nxt : w_mul_nxt;
      end
   end

   // HI/LO: result write in FIX, MTHI/MTLO only while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_FIX && !flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
         end else if (r_state == S_IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
